// File: rtl/dmem_line_responder_if.sv
// Request/ack bus between the L1 data-cache controller (master) and the line memory (slave).
// Optional err_o is present only when DMEM_MISALIGN_CHECK_EN is defined.
interface dmem_line_responder_if;
  // enable_i is sampled only while the responder is idle. ack_o is a single-cycle
  // completion pulse. data_o is meaningful only while ack_o is high.
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic         err_o;

  modport master (output enable_i, write_i, addr_i, data_i, input ack_o, data_o, err_o);
  modport slave  (input enable_i, write_i, addr_i, data_i, output ack_o, data_o, err_o);
`else
  modport master (output enable_i, write_i, addr_i, data_i, input ack_o, data_o);
  modport slave  (input enable_i, write_i, addr_i, data_i, output ack_o, data_o);
`endif
endinterface

// File: rtl/dmem_line_responder.sv
// Line-granular backing memory: one 256-bit line per request, acked after a fixed LATENCY.
// Optional misalignment flag err_o is built when DMEM_MISALIGN_CHECK_EN is defined.
module dmem_line_responder #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int IDX_W   = 9
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  dmem_line_responder_if.slave    bus,
  output logic [1:0]              dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               wr_q, wr_d;
  logic [255:0]       wdata_q, wdata_d;
  logic               mis_q, mis_d;
  logic               unused_addr;

  logic [255:0] mem [DEPTH];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          idx_d   = bus.addr_i[IDX_W+4:5];
          wr_d    = bus.write_i;
          wdata_d = bus.data_i;
          mis_d   = (bus.addr_i[4:0] != 5'd0);
          cnt_d   = 8'(LATENCY - 1);
          state_d = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        // Request inputs are ignored here; only the latched copies matter.
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write-back commits at the end of the ack cycle; an async reset before then drops it.
  always_ff @(posedge clk_i) begin
    if (state_q == DONE && wr_q) mem[idx_q] <= wdata_q;
  end

  assign bus.ack_o   = (state_q == DONE);
  assign bus.data_o  = (state_q == DONE && !wr_q) ? mem[idx_q] : '0;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign bus.err_o   = (state_q == DONE) && mis_q;
`endif
  assign dbg_state_o = state_q;
  assign unused_addr = ^{bus.addr_i[31:IDX_W+5], bus.addr_i[4:0], mis_q};

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed self-checking bench for dmem_line_responder (define DMEM_MISALIGN_CHECK_EN to cover err_o).
module tb_dmem_line_responder;

  localparam int LAT = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] dbg_state;
  int checks = 0;
  int errors = 0;
  logic [255:0] exp_q[$];
  logic last_err;

  dmem_line_responder_if bus();

  dmem_line_responder #(.LATENCY(LAT), .DEPTH(512), .IDX_W(9)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Driver: called at a negedge; request is sampled at the next posedge.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [255:0] d, input string tag);
    int lat;
    logic [255:0] exp;
    bus.enable_i = 1'b1;
    bus.write_i  = wr;
    bus.addr_i   = addr;
    bus.data_i   = d;
    @(posedge clk);
    @(negedge clk);
    bus.enable_i = 1'b0;
    bus.write_i  = 1'($urandom_range(0, 1));
    bus.addr_i   = $urandom;
    bus.data_i   = {8{$urandom}};
    lat = 1;
    while (bus.ack_o !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 256'(lat), 256'(LAT));
    if (wr) begin
      check({tag, "_wdata0"}, bus.data_o, 256'd0);
    end else begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 256'd0;
      check({tag, "_rdata"}, bus.data_o, exp);
    end
`ifdef DMEM_MISALIGN_CHECK_EN
    last_err = bus.err_o;
`else
    last_err = 1'b0;
`endif
    @(negedge clk);
    check({tag, "_ack_low"}, 256'(bus.ack_o), 256'd0);
    check({tag, "_data_low"}, bus.data_o, 256'd0);
  endtask

  initial begin
    logic [255:0] pat_a, pat_b, pat_p, pat_z, ones;
    int ack_cyc[$];
    int ack_cnt;
    pat_a = {32{8'h5A}};
    pat_b = {8{32'h0123_4567}};
    pat_p = {32{8'hC3}};
    pat_z = {16{16'hBEEF}};
    ones  = '1;
    last_err = 1'b0;

    rst_n = 1'b0;
    bus.enable_i = 1'b0;
    bus.write_i  = 1'b0;
    bus.addr_i   = 32'd0;
    bus.data_i   = '0;

    // Reset then idle
    repeat (3) @(negedge clk);
    check("rst_ack", 256'(bus.ack_o), 256'd0);
    check("rst_data", bus.data_o, 256'd0);
    check("rst_state", 256'(dbg_state), 256'd0);
    rst_n = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ack_o !== 1'b0 || bus.data_o !== 256'd0) ack_cnt++;
    end
    check("idle_quiet", 256'(ack_cnt), 256'd0);

    // Write then back-to-back read of the same line
    txn(1'b1, 32'h0000_0040, pat_a, "wr40");
    exp_q.push_back(pat_a);
    txn(1'b0, 32'h0000_0040, '0, "rd40");

    // Another line stays independent
    txn(1'b1, 32'h0000_0060, pat_b, "wr60");
    exp_q.push_back(pat_b);
    txn(1'b0, 32'h0000_0060, '0, "rd60");
    exp_q.push_back(pat_a);
    txn(1'b0, 32'h0000_0040, '0, "rd40b");

    // Index wraps modulo DEPTH
    txn(1'b1, 32'h0000_4020, 256'd1, "wr4020");
    exp_q.push_back(256'd1);
    txn(1'b0, 32'h0000_0020, '0, "rd20");

    // Offset bits ignored for the line; err_o flags them when built in
    exp_q.push_back(pat_a);
    txn(1'b0, 32'h0000_0044, '0, "rd44");
`ifdef DMEM_MISALIGN_CHECK_EN
    check("err44", 256'(last_err), 256'd1);
`endif
    exp_q.push_back(pat_a);
    txn(1'b0, 32'h0000_0040, '0, "rd40c");
`ifdef DMEM_MISALIGN_CHECK_EN
    check("err40", 256'(last_err), 256'd0);
`endif

    // enable held high: acks every LAT+1 cycles
    txn(1'b1, 32'h0000_0000, pat_z, "wr00");
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b0;
    bus.addr_i   = 32'd0;
    ack_cnt = 0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (bus.ack_o === 1'b1) begin
        ack_cyc.push_back(c);
        if (bus.data_o !== pat_z) ack_cnt++;
      end
      if (c == 33) bus.enable_i = 1'b0;
    end
    check("hold_nacks", 256'(ack_cyc.size()), 256'd3);
    check("hold_data", 256'(ack_cnt), 256'd0);
    if (ack_cyc.size() == 3) begin
      check("hold_ack1", 256'(ack_cyc[0]), 256'd10);
      check("hold_ack2", 256'(ack_cyc[1]), 256'd21);
      check("hold_ack3", 256'(ack_cyc[2]), 256'd32);
    end
    @(negedge clk);

    // Reset mid-write: abort, no ack, prior contents kept
    txn(1'b1, 32'h0000_0080, pat_p, "wr80");
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h0000_0080;
    bus.data_i   = ones;
    @(posedge clk);
    @(negedge clk);
    bus.enable_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    ack_cnt = 0;
    @(negedge clk);
    check("midrst_state", 256'(dbg_state), 256'd0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (bus.ack_o === 1'b1) ack_cnt++;
    end
    check("midrst_noack", 256'(ack_cnt), 256'd0);
    exp_q.push_back(pat_p);
    txn(1'b0, 32'h0000_0080, '0, "rd80");

    check("expq_empty", 256'(exp_q.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_line_responder.md
Name: dmem_line_responder

Overview:
- Line-granular backing data memory that answers the L1 data-cache controller's refill and write-back requests.
- Sits on the memory side of the cache, opposite the controller that drives the tag/data SRAM.
- Transfers one 256-bit (32-byte) line per request over a request/ack handshake with a fixed, programmable latency.
- Models main-memory delay cycle-accurately for the pipeline.

Parameters:
- LATENCY, 10: cycles from request sample to ack_o; legal range 1..255.
- DEPTH, 512: number of 256-bit lines (16 KB); power of two.
- IDX_W, 9: log2(DEPTH); line index = addr_i[IDX_W+4:5].

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- enable_i  input  1  request valid from cache controller.
- write_i  input  1  1 = write-back line, 0 = refill read.
- addr_i  input  32  byte address; bits [4:0] ignored, bits above IDX_W+4 ignored (index wraps modulo DEPTH).
- data_i  input  256  write-back line data.
- ack_o  output  1  one-cycle completion pulse.
- data_o  output  256  read line data, valid only while ack_o=1.

Behaviour:
- Reset (rst_i low, async): state=IDLE, counter=0, ack_o=0, data_o=0, latched request cleared. Memory array is not reset.
- Reset mid-operation aborts the request: no write committed, no ack issued.
- States: IDLE, BUSY, DONE.
- IDLE: on a rising edge with enable_i=1, latch addr index, write_i and data_i; load counter=LATENCY-1; go to BUSY. If LATENCY=1, go directly to DONE.
- BUSY: decrement counter each cycle. When counter reaches 1, go to DONE next edge. enable_i/addr_i/data_i/write_i are ignored; latched copies are used.
- DONE: ack_o=1 for exactly this one cycle.
  - Read: data_o = mem[latched index] during this cycle.
  - Write: mem[latched index] <= latched data at the end of this cycle; data_o=0.
  - Next state is always IDLE; enable_i is not sampled in DONE.
- Timing: request sampled at edge T gives ack_o high in cycle T+LATENCY (registered output). Minimum spacing between two request samples is LATENCY+1 edges.
- Controller holding enable_i high through the IDLE cycle after DONE starts a new transaction (back-to-back allowed).
- Outside DONE: ack_o=0 and data_o=0.
- Read-after-write to the same line in consecutive transactions returns the newly written data.
- No partial-line writes; no byte enables.

Optional Feature:
- Macro DMEM_MISALIGN_CHECK_EN.
- Defined:
  - Adds output port err_o (1 bit), reset 0.
  - err_o pulses together with ack_o when the latched addr_i[4:0] != 0.
  - The access is still performed on the aligned line.
- Undefined: no err_o port; addr_i[4:0] silently ignored.

Test Plan:
- Reset then idle: rst_i low 3 cycles, release, enable_i=0 for 20 cycles -> ack_o=0 and data_o=0 throughout.
- Write/read: write line 0x5A5A..5A to addr 0x0000_0040 sampled at edge T -> ack_o high only in cycle T+10. Read of 0x40 sampled at T+11 -> ack at T+21, data_o=0x5A5A..5A.
- Latency/hold: enable_i held high continuously with reads of 0x00 -> acks spaced exactly 11 cycles apart. Changing addr_i mid-BUSY does not alter the returned data.
- Wrap: write 0x1 to addr 0x0000_4020 (index 1 modulo 512), read addr 0x0000_0020 -> data_o=0x1.
- Reset mid-write: write 0xFF.. to 0x80, pull rst_i low at cycle T+5 -> no ack. Subsequent read of 0x80 returns prior contents.
- With DMEM_MISALIGN_CHECK_EN: read addr 0x0000_0044 -> err_o=1 in the ack cycle, data_o = line at 0x40. Read of 0x40 -> err_o=0.
